// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: shared types, counter width and select range helper for the stream demux
package stream_demux_pkg;
  localparam int CNT_W = 16;
  typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_t;
  function automatic logic sel_in_range(input int sel, input int n);
    return sel < n;
  endfunction
endpackage

// File: rtl/stream_demux_if.sv
// stream_demux_if: input stream plus N output channel bundle of the demux
interface stream_demux_if #(parameter int N = 4, parameter int W = 8);
  localparam int SW = $clog2(N);
  logic in_valid;
  logic in_ready;
  logic [SW-1:0] in_sel;
  logic [W-1:0] in_data;
  logic [N-1:0] out_valid;
  logic [N-1:0] out_ready;
  logic [N*W-1:0] out_data;
  logic drop;
  modport master(output in_valid, in_sel, in_data, out_ready, input in_ready, out_valid, out_data, drop);
  modport slave(input in_valid, in_sel, in_data, out_ready, output in_ready, out_valid, out_data, drop);
endinterface

// File: rtl/stream_demux_slot.sv
// stream_demux_slot: one-entry holding register for a single output channel
module stream_demux_slot import stream_demux_pkg::*; #(parameter int W = 8) (
  input logic clk,
  input logic rst_n,
  input logic fill,
  input logic drain,
  input logic [W-1:0] d,
  output logic valid,
  output logic [W-1:0] q
);
  slot_state_t st;
  assign valid = st == SLOT_FULL;
  // fill wins over drain so a simultaneous drain and fill keeps the slot full
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= SLOT_EMPTY;
      q <= '0;
    end else begin
      st <= fill ? SLOT_FULL : drain ? SLOT_EMPTY : st;
      if (fill) q <= d;
    end
endmodule

// File: rtl/stream_demux.sv
// stream_demux: registered 1-to-N stream demultiplexer; STREAM_DEMUX_COUNT_EN adds per-channel transfer counters
module stream_demux import stream_demux_pkg::*; #(parameter int N = 4, parameter int W = 8) (
  input logic clk,
  input logic rst_n,
  stream_demux_if.slave s
`ifdef STREAM_DEMUX_COUNT_EN
  , output logic [N*CNT_W-1:0] xfer_cnt
`endif
);
  localparam int SW = $clog2(N);
  logic in_rng;
  logic [N-1:0] fill, drain;
  assign in_rng = sel_in_range(32'(s.in_sel), N);
  assign s.in_ready = !in_rng || !s.out_valid[s.in_sel] || s.out_ready[s.in_sel];
  for (genvar i = 0; i < N; i++) begin : g_ch
    assign fill[i] = s.in_valid && s.in_ready && in_rng && s.in_sel == SW'(i);
    assign drain[i] = s.out_valid[i] && s.out_ready[i];
    stream_demux_slot #(.W(W)) u_slot (
      .clk(clk),
      .rst_n(rst_n),
      .fill(fill[i]),
      .drain(drain[i]),
      .d(s.in_data),
      .valid(s.out_valid[i]),
      .q(s.out_data[i*W +: W])
    );
`ifdef STREAM_DEMUX_COUNT_EN
    // count output transfers, wrapping naturally at the counter width
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) xfer_cnt[i*CNT_W +: CNT_W] <= '0;
      else if (drain[i]) xfer_cnt[i*CNT_W +: CNT_W] <= xfer_cnt[i*CNT_W +: CNT_W] + 1'b1;
`endif
  end
  // flag words accepted with an out-of-range select, one cycle after acceptance
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) s.drop <= 1'b0;
    else s.drop <= s.in_valid && !in_rng;
endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux: table-driven and directed self-checking bench for stream_demux
module tb_stream_demux;
  import stream_demux_pkg::*;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  stream_demux_if #(.N(4), .W(8)) b4();
  stream_demux_if #(.N(3), .W(8)) b3();
`ifdef STREAM_DEMUX_COUNT_EN
  logic [4*CNT_W-1:0] cnt4;
  logic [3*CNT_W-1:0] cnt3;
`endif
  stream_demux #(.N(4), .W(8)) dut4 (
    .clk(clk),
    .rst_n(rst_n),
    .s(b4)
`ifdef STREAM_DEMUX_COUNT_EN
    , .xfer_cnt(cnt4)
`endif
  );
  stream_demux #(.N(3), .W(8)) dut3 (
    .clk(clk),
    .rst_n(rst_n),
    .s(b3)
`ifdef STREAM_DEMUX_COUNT_EN
    , .xfer_cnt(cnt3)
`endif
  );
  typedef struct {
    logic v;
    logic [1:0] sel;
    logic [7:0] d;
    logic [3:0] ordy;
    logic rdy;
    logic [3:0] ov;
    logic [31:0] od;
  } vec_t;
  vec_t tbl[12];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive4(input logic v, input logic [1:0] sel, input logic [7:0] d, input logic [3:0] ordy);
    b4.in_valid = v;
    b4.in_sel = sel;
    b4.in_data = d;
    b4.out_ready = ordy;
  endtask
  initial begin
    tbl[0]  = '{1'b1, 2'd2, 8'hA5, 4'b0000, 1'b1, 4'b0100, 32'h00A50000};
    tbl[1]  = '{1'b1, 2'd1, 8'h11, 4'b0000, 1'b1, 4'b0110, 32'h00A51100};
    tbl[2]  = '{1'b1, 2'd1, 8'h22, 4'b0000, 1'b0, 4'b0110, 32'h00A51100};
    tbl[3]  = '{1'b1, 2'd1, 8'h22, 4'b0010, 1'b1, 4'b0110, 32'h00A52200};
    tbl[4]  = '{1'b0, 2'd0, 8'h00, 4'b0110, 1'b1, 4'b0000, 32'h00A52200};
    tbl[5]  = '{1'b1, 2'd0, 8'h33, 4'b0000, 1'b1, 4'b0001, 32'h00A52233};
    tbl[6]  = '{1'b1, 2'd1, 8'h44, 4'b0000, 1'b1, 4'b0011, 32'h00A54433};
    tbl[7]  = '{1'b1, 2'd2, 8'h55, 4'b0000, 1'b1, 4'b0111, 32'h00554433};
    tbl[8]  = '{1'b1, 2'd3, 8'h66, 4'b0000, 1'b1, 4'b1111, 32'h66554433};
    tbl[9]  = '{1'b1, 2'd0, 8'h77, 4'b1110, 1'b0, 4'b0001, 32'h66554433};
    tbl[10] = '{1'b1, 2'd0, 8'h77, 4'b0001, 1'b1, 4'b0001, 32'h66554477};
    tbl[11] = '{1'b0, 2'd0, 8'h00, 4'b0001, 1'b1, 4'b0000, 32'h66554477};
    rst_n = 1'b0;
    drive4(1'b1, 2'd2, 8'hA5, 4'b0000);
    b3.in_valid = 1'b0;
    b3.in_sel = 2'd0;
    b3.in_data = 8'h00;
    b3.out_ready = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(b4.out_valid), 64'h0);
    chk("reset_out_data", 64'(b4.out_data), 64'h0);
    chk("reset_drop", 64'(b4.drop), 64'h0);
`ifdef STREAM_DEMUX_COUNT_EN
    chk("reset_cnt", 64'(cnt4), 64'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      drive4(tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].ordy);
      #1;
      chk($sformatf("vec%0d_in_ready", i), 64'(b4.in_ready), 64'(tbl[i].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_out_valid", i), 64'(b4.out_valid), 64'(tbl[i].ov));
      chk($sformatf("vec%0d_out_data", i), 64'(b4.out_data), 64'(tbl[i].od));
      chk($sformatf("vec%0d_drop", i), 64'(b4.drop), 64'h0);
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive4(1'b1, 2'(i % 4), 8'(i), 4'b1111);
      #1;
      chk($sformatf("stream%0d_in_ready", i), 64'(b4.in_ready), 64'h1);
      @(posedge clk);
      #1;
      chk($sformatf("stream%0d_out_valid", i), 64'(b4.out_valid), 64'(4'b0001 << (i % 4)));
      chk($sformatf("stream%0d_out_data", i), 64'(b4.out_data[(i % 4)*8 +: 8]), 64'(i));
    end
    @(negedge clk);
    drive4(1'b0, 2'd0, 8'h00, 4'b1111);
    @(posedge clk);
    #1;
    chk("stream_drained", 64'(b4.out_valid), 64'h0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive4(1'b1, 2'(c), 8'(8'hC0 + c), 4'b0000);
      @(posedge clk);
    end
    @(negedge clk);
    drive4(1'b0, 2'd0, 8'h00, 4'b0000);
    #1;
    chk("all_full", 64'(b4.out_valid), 64'hF);
    chk("all_full_data", 64'(b4.out_data), 64'hC3C2C1C0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", 64'(b4.out_valid), 64'h0);
    chk("midreset_out_data", 64'(b4.out_data), 64'h0);
`ifdef STREAM_DEMUX_COUNT_EN
    chk("midreset_cnt", 64'(cnt4), 64'h0);
`endif
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    b3.in_valid = 1'b1;
    b3.in_sel = 2'd3;
    b3.in_data = 8'h7E;
    #1;
    chk("oor_in_ready", 64'(b3.in_ready), 64'h1);
    @(posedge clk);
    #1;
    chk("oor_drop", 64'(b3.drop), 64'h1);
    chk("oor_out_valid", 64'(b3.out_valid), 64'h0);
    @(negedge clk);
    b3.in_sel = 2'd2;
    @(posedge clk);
    #1;
    chk("inrange_drop", 64'(b3.drop), 64'h0);
    chk("inrange_out_valid", 64'(b3.out_valid), 64'h4);
    chk("inrange_out_data", 64'(b3.out_data), 64'h7E0000);
    @(negedge clk);
    b3.in_valid = 1'b0;
    b3.in_sel = 2'd3;
    @(posedge clk);
    #1;
    chk("idle_drop", 64'(b3.drop), 64'h0);
    chk("hold_out_valid", 64'(b3.out_valid), 64'h4);
`ifdef STREAM_DEMUX_COUNT_EN
    for (int i = 0; i < 65536; i++) begin
      @(negedge clk);
      drive4(1'b1, 2'd0, 8'(i), 4'b0001);
      @(posedge clk);
      #1;
      if (i == 1) chk("cnt_one", 64'(cnt4[15:0]), 64'h1);
    end
    @(negedge clk);
    drive4(1'b0, 2'd0, 8'h00, 4'b0001);
    @(posedge clk);
    #1;
    chk("cnt_wrap", 64'(cnt4), 64'h0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- Registered 1-to-N stream demultiplexer; the routing inverse of the 2:1 mux primitive.
- One valid/ready input stream carries a channel index per word. The word is steered into a one-entry holding slot on the selected output channel.
- Sits between a shared producer (e.g. an arbiter or mux tree output) and N independent consumers.
- Each channel stalls independently; a blocked channel does not block the others except when the head-of-line input word targets it.

Parameters:
- N, 4, number of output channels (2..16).
- W, 8, data width in bits.
- SW, $clog2(N), select width (derived localparam, not overridable).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input word present
- in_ready  output  1  input word accepted this cycle when in_valid is also high
- in_sel  input  SW  target channel index
- in_data  input  W  input word
- out_valid  output  N  bit i: channel i slot holds a word
- out_ready  input  N  bit i: channel i consumer takes the word
- out_data  output  N*W  channel i word at bits [i*W +: W]
- drop  output  1  one-cycle pulse: an accepted word had in_sel >= N and was discarded

Behaviour:
- Reset values: all out_valid bits 0, out_data 0, drop 0, all internal slots empty. Reset is asynchronous at assertion; the first clock edge after rst_n rises behaves as a normal cycle.
- Reset mid-operation: all held words are lost and all valids clear immediately.
- Transfer rule: a transfer happens on an edge where valid && ready. Data must be held stable while valid is high and ready is low. Valid must not drop before the transfer.
- in_ready is combinational from in_sel, slot state and out_ready:
  - in_sel >= N: in_ready = 1 (the word is consumed and dropped).
  - Otherwise: in_ready = (slot[in_sel] empty) OR out_ready[in_sel].
- Latency: a word accepted at edge k appears at out_valid/out_data of channel in_sel after edge k, i.e. 1 cycle.
- Per-slot states (a 2-state machine per channel):
  - EMPTY -> FULL on fill.
  - FULL -> EMPTY on drain without fill.
  - FULL -> FULL on simultaneous drain and fill. The new word replaces the old one in the same edge, so full throughput is 1 word/cycle per channel.
- Only one slot can fill per cycle. Slots of other channels drain freely in the same cycle.
- out_data of channel i changes only on a fill of slot i. It holds its value when empty; the value then is don't-care to the consumer but is deterministic.
- drop is a registered pulse, asserted the cycle after the accepting edge. It is 0 when N is a power of two, because the condition is unreachable.
- The block does not reorder words within a channel. No combinational path from in_valid to out_valid.

Optional Feature:
- Macro: STREAM_DEMUX_COUNT_EN
- Defined: adds output port xfer_cnt (N*16 bits). 16-bit counter i increments on each channel i output transfer (out_valid[i] && out_ready[i]) and wraps 0xFFFF -> 0x0000. Counters reset to 0.
- Not defined: port and counters absent; behaviour otherwise identical.

Decomposition:
- Package stream_demux_pkg holds:
  - the CNT_W = 16 localparam;
  - slot_state_t enum {SLOT_EMPTY, SLOT_FULL};
  - a function sel_in_range(sel, n).
- Sub-module stream_demux_slot:
  - one-entry register with fill / drain / state;
  - parameter W;
  - instantiated N times in a generate loop.
- Top level holds the select decode, in_ready logic, drop register and optional counters.

Test Plan:
- Reset: hold rst_n = 0 with in_valid = 1, in_sel = 2, in_data = 0xA5 -> out_valid = 0000, in_ready ignored, drop = 0. Release, present one word -> out_valid = 0100 next cycle, out_data[23:16] = 0xA5.
- Backpressure: out_ready = 0000, send 0x11 to channel 1, then 0x22 to channel 1 -> second word sees in_ready = 0 and stalls. Set out_ready[1] = 1 -> 0x11 drains and 0x22 loads on the same edge, out_valid[1] stays 1.
- Streaming: out_ready = 1111, words 0..15 with in_sel = i%4 every cycle -> in_ready constantly 1, each channel receives i, i+4, ... in order, 1-cycle latency.
- Independence: channel 0 stalled and full, words to channels 1..3 -> accepted without stall.
- Out of range (N = 3, SW = 2): in_sel = 3, data 0x7E -> in_ready = 1, drop = 1 one cycle later, no out_valid change.
- Mid-operation reset: all slots full, pulse rst_n low between edges -> out_valid = 0 immediately, before the next edge. With STREAM_DEMUX_COUNT_EN, xfer_cnt = 0 and a 65536-transfer run on channel 0 wraps to 0.
